// File: rtl/ram_loader.sv
// ram_loader: boot-time byte-stream to 16-bit RAM word loader; RAM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module ram_loader #(
  parameter int addr_size = 16,
  parameter int data_size = 16,
  parameter logic [addr_size-1:0] base_addr = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 start,
  output logic                 wenable,
  output logic [addr_size-1:0] waddr,
  output logic [data_size-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  if (data_size != 16) begin : g_bad_width
    $error("ram_loader: data_size must be 16");
  end
`ifdef RAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, FLUSH, DONE} state_t;
  localparam state_t last_st = CHK;
  logic [7:0] xsum;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA_LO, DATA_HI, FLUSH, DONE} state_t;
  localparam state_t last_st = FLUSH;
  assign err = 1'b0;
`endif
  state_t state;
  logic [15:0] n;
  logic [15:0] idx;
  logic [7:0] lo;
  logic acc;
  assign in_ready = state != FLUSH && state != DONE;
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= LEN_LO;
      n       <= '0;
      idx     <= '0;
      lo      <= '0;
      wenable <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      err     <= 1'b0;
      xsum    <= '0;
`endif
    end else begin
      wenable <= 1'b0;
      case (state)
        LEN_LO: if (acc) begin
          n[7:0] <= in_data;
          state  <= LEN_HI;
        end
        LEN_HI: if (acc) begin
          n[15:8] <= in_data;
          state   <= {in_data, n[7:0]} == 16'd0 ? last_st : DATA_LO;
        end
        DATA_LO: if (acc) begin
          lo    <= in_data;
          state <= DATA_HI;
        end
        DATA_HI: if (acc) begin
          wenable <= 1'b1;
          waddr   <= base_addr + addr_size'(idx);
          wdata   <= data_size'({in_data, lo});
          idx     <= idx + 16'd1;
          state   <= 17'(idx) + 17'd1 < 17'(n) ? DATA_LO : last_st;
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        CHK: if (acc) begin
          err   <= in_data != xsum;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: if (start) begin
          state <= LEN_LO;
          idx   <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
          err   <= 1'b0;
          xsum  <= '0;
`endif
        end
        default: state <= LEN_LO;
      endcase
`ifdef RAM_LOADER_CHECKSUM_EN
      if (acc && state != CHK) xsum <= xsum ^ in_data;
`endif
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed table-driven bench for ram_loader; follows RAM_LOADER_CHECKSUM_EN if defined.
module tb_ram_loader;
  logic clk = 1'b0;
  logic rstn, in_valid, start;
  logic [7:0] in_data;
  logic in_ready, wenable, busy, done, err;
  logic [15:0] waddr, wdata;
  logic z_ready, z_wen, z_busy, z_done, z_err;
  logic [3:0] z_addr;
  logic [15:0] z_data;
  int tests = 0, fails = 0;
  logic [31:0] wq[$];
  logic [19:0] zq[$];
  logic [15:0] ram [0:15];
  typedef struct {
    logic [63:0] s;
    int nb;
    int gap;
    int nw;
    logic [47:0] d;
    logic [11:0] wa;
  } vec_t;
  vec_t v[5];

  ram_loader dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .wenable(wenable), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );
  ram_loader #(.addr_size(4), .base_addr(4'd14)) dut_wrap (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ready(z_ready),
    .start(start), .wenable(z_wen), .waddr(z_addr), .wdata(z_data),
    .busy(z_busy), .done(z_done), .err(z_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && wenable) begin
      wq.push_back({waddr, wdata});
      ram[waddr[3:0]] = wdata;
    end
    if (rstn && z_wen) zq.push_back({z_addr, z_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    idle(1);
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic finish_load(input logic [7:0] x);
`ifdef RAM_LOADER_CHECKSUM_EN
    send(x);
    @(negedge clk);
    chk("done_after_chk", 32'(done), 32'd1);
    chk("err_good_sum", 32'(err), 32'd0);
`else
    @(negedge clk);
    chk("done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_latency", 32'(done), 32'd1);
    chk("err_zero", 32'(err), 32'd0);
`endif
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd0);
    chk("done_wen", 32'(wenable), 32'd0);
  endtask

  task automatic run_vec(input int i);
    logic [7:0] x, b;
    wq.delete();
    zq.delete();
    x = 8'h00;
    for (int k = 0; k < v[i].nb; k++) begin
      b = v[i].s[8*k +: 8];
      x ^= b;
      send(b);
      if (k < v[i].nb - 1) idle(v[i].gap);
    end
    finish_load(x);
    chk($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(v[i].nw));
    chk($sformatf("v%0d_wrap_nwrites", i), 32'(zq.size()), 32'(v[i].nw));
    for (int j = 0; j < v[i].nw && j < wq.size() && j < zq.size(); j++) begin
      chk($sformatf("v%0d_waddr%0d", i, j), 32'(wq[j][31:16]), 32'(j));
      chk($sformatf("v%0d_wdata%0d", i, j), 32'(wq[j][15:0]), 32'(v[i].d[16*j +: 16]));
      chk($sformatf("v%0d_wrap_addr%0d", i, j), 32'(zq[j][19:16]), 32'(v[i].wa[4*j +: 4]));
    end
  endtask

  initial begin
    v[0] = '{s: 64'h0000_ABCD_1234_0002, nb: 6, gap: 0, nw: 2, d: 48'h0000_ABCD_1234, wa: 12'h0FE};
    v[1] = '{s: 64'h0000_0000_0000_0000, nb: 2, gap: 0, nw: 0, d: 48'h0, wa: 12'h0};
    v[2] = '{s: 64'h0000_ABCD_1234_0002, nb: 6, gap: 3, nw: 2, d: 48'h0000_ABCD_1234, wa: 12'h0FE};
    v[3] = '{s: 64'h3333_2222_1111_0003, nb: 8, gap: 0, nw: 3, d: 48'h3333_2222_1111, wa: 12'h0FE};
    v[4] = '{s: 64'h0000_0000_BEEF_0001, nb: 4, gap: 1, nw: 1, d: 48'h0000_0000_BEEF, wa: 12'h00E};
    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    start = 1'b0;
    idle(2);
    @(negedge clk);
    chk("rst_wen", 32'(wenable), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) do_start();
      run_vec(i);
    end
    chk("ram0", 32'(ram[0]), 32'h1111);
    chk("ram1", 32'(ram[1]), 32'h2222);
    chk("ram2", 32'(ram[2]), 32'h3333);
    in_valid = 1'b1;
    in_data = 8'h55;
    idle(3);
    @(negedge clk);
    chk("done_ignores_ready", 32'(in_ready), 32'd0);
    chk("done_ignores_done", 32'(done), 32'd1);
    chk("done_ignores_writes", 32'(wq.size()), 32'd3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    do_start();
    send(8'h02);
    send(8'h00);
    send(8'h34);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_wen", 32'(wenable), 32'd0);
    chk("midrst_waddr", 32'(waddr), 32'd0);
    chk("midrst_wdata", 32'(wdata), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    run_vec(0);
    chk("reload_ram0", 32'(ram[0]), 32'h1234);
    chk("reload_ram1", 32'(ram[1]), 32'hABCD);
    do_start();
    run_vec(4);
    chk("restart_ram0", 32'(ram[0]), 32'hBEEF);
    chk("restart_ram1", 32'(ram[1]), 32'hABCD);
`ifdef RAM_LOADER_CHECKSUM_EN
    do_start();
    send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h27);
    @(negedge clk);
    chk("sum_ok_err", 32'(err), 32'd0);
    chk("sum_ok_done", 32'(done), 32'd1);
    do_start();
    send(8'h01); send(8'h00); send(8'h34); send(8'h12); send(8'h00);
    @(negedge clk);
    chk("sum_bad_err", 32'(err), 32'd1);
    chk("sum_bad_done", 32'(done), 32'd1);
    idle(2);
    @(negedge clk);
    chk("sum_bad_err_holds", 32'(err), 32'd1);
    do_start();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time program loader directly upstream of the RAM write port.
- Consumes a byte stream (UART receiver or debug link) with valid/ready handshake.
- Assembles little-endian 16-bit words and drives RAM wenable/waddr/wdata.
- Holds the CPU in `busy` until the image is fully written, then raises `done`.

Parameters:
- addr_size, 16, RAM address width; must match the RAM instance.
- data_size, 16, RAM word width; fixed at 16. Other values are unsupported, and elaboration fails via a static assertion.
- base_addr, 0, first RAM address written; width addr_size.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- start  in  1  one-cycle pulse; re-arms the loader from DONE
- wenable  out  1  RAM write enable (one-cycle pulse per word)
- waddr  out  addr_size  RAM write address
- wdata  out  data_size  RAM write data
- busy  out  1  load in progress; CPU held while high
- done  out  1  load complete, all writes committed
- err  out  1  checksum mismatch (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low, on rstn; clock is clk.
- Reset state is LEN_LO. Output values during and after reset:
  - wenable=0, waddr=0, wdata=0
  - busy=1, done=0, err=0
  - word counter=0, word index=0
- All outputs are registered. in_ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK; 0 in FLUSH and DONE.
- A byte is accepted on a rising edge with in_valid && in_ready. in_data is ignored otherwise. in_valid may drop between bytes; no timeout.
- Stream format: N_lo, N_hi, then N words, each sent as lo byte then hi byte. N is a 16-bit word count.
- State transitions on an accepted byte:
  - LEN_LO: latch N[7:0] -> LEN_HI.
  - LEN_HI: latch N[15:8]. If N==0 -> FLUSH (or CHK with feature); else -> DATA_LO.
  - DATA_LO: latch lo byte -> DATA_HI.
  - DATA_HI, at the same edge:
    - wenable<=1
    - waddr<=base_addr+idx, modulo 2^addr_size (wraps)
    - wdata<={hi,lo}
    - idx<=idx+1
    - next state: DATA_LO if idx+1<N; else FLUSH (or CHK with feature).
- wenable is high for exactly one cycle per word and cleared on the following edge. waddr/wdata hold their last value.
- FLUSH: one cycle, unconditional -> DONE. This guarantees the final write has been committed to RAM before done rises.
- DONE: busy=0, done=1.
  - start pulse -> LEN_LO, with busy=1, done=0, err=0, idx=0.
  - start in any other state is ignored.
- Latency: the last word is in RAM at the edge after its hi byte is accepted. done is observable 2 cycles after that acceptance edge.
- N greater than 2^addr_size: addresses wrap and earlier words are overwritten. No error is raised.
- Reset mid-transfer: immediate abort and return to LEN_LO. Partial RAM contents are untouched; the RAM clears itself on the same reset.

Optional Feature:
- Macro: RAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR is kept over every accepted byte, including the two length bytes.
  - After the last word (or after LEN_HI when N==0), state CHK accepts one byte. The write pulse from the final hi byte still completes normally.
  - If that byte != running XOR, err<=1. In either case -> DONE directly (no FLUSH needed, since the write has already committed).
  - err holds until reset or start. The XOR is cleared on reset and on start.
- Undefined: no CHK state, no XOR register; err is tied to 0.

Test Plan:
- Basic load, base_addr=0, stream 02 00 34 12 CD AB, in_valid continuous:
  - wenable pulses with (0,0x1234) then (1,0xABCD).
  - done=1 two cycles after the AB byte; RAM[0]=0x1234, RAM[1]=0xABCD.
- Empty image, stream 00 00 -> no wenable pulse; done=1 two cycles after the second byte; busy=0.
- Backpressure/gaps: same stream as the basic load with in_valid low for 3 cycles between every byte -> identical writes. in_ready=0 in FLUSH/DONE and no bytes are consumed there.
- Wrap-around, addr_size=4, base_addr=14, N=3, words 0x1111, 0x2222, 0x3333 -> writes to addresses 14, 15, 0.
- Reset mid-transfer: rstn low after 3 bytes of the basic-load stream -> outputs return to reset values. A fresh full stream then loads correctly. Afterwards, a start pulse in DONE with a second stream overwrites RAM and done re-asserts.
- With RAM_LOADER_CHECKSUM_EN:
  - Stream 01 00 34 12 then 27 -> err=0, done=1.
  - Same stream with final byte 00 -> err=1, done=1; err clears on the next start.
